leaf_out_arbiter: RTL and testbench
===================================

// Module: leaf_out_arbiter
// PURPOSE
//  Credit-based round-robin scheduler sharing one leaf's BFT output link among NUM_OUT_PORTS user output streams.
//  Sits between per-port output packetisers and dout_leaf_interface2bft. Picks one eligible port per cycle and registers its packet onto the link.
//  Tracks per-port downstream free space (credits) and holds/replays the packet while the network asserts resend.
// PARAMETERS
//  PACKET_BITS            49   link packet width; bit [PACKET_BITS-1] is the packet-valid bit
//  NUM_OUT_PORTS          4    number of requesting output streams (1..16)
//  NUM_PORT_BITS          4    width of port index in credit updates
//  CREDIT_BITS            8    credit counter width
//  INIT_CREDITS           128  credits per port after reset (= destination BRAM depth, 2^NUM_BRAM_ADDR_BITS)
//  FREESPACE_UPDATE_SIZE  64   credits added by one free-space update
// PORTS
//  clk_bft          in   1                           BFT-side clock; all logic on this clock
//  reset_bft        in   1                           synchronous, active-high reset
//  req_vld          in   NUM_OUT_PORTS               port i has a packet on req_pkt slice i
//  req_pkt          in   NUM_OUT_PORTS*PACKET_BITS   packed packets; port i at [i*PACKET_BITS +: PACKET_BITS]
//  req_ack          out  NUM_OUT_PORTS               one-hot; port i packet consumed this cycle
//  credit_upd_vld   in   1                           free-space update received from network
//  credit_upd_port  in   NUM_PORT_BITS               port the update applies to
//  resend           in   1                           network rejected the packet currently on the link
//  dout_leaf_interface2bft out PACKET_BITS           registered link packet; all-zero when idle
//  credit_cnt       out  NUM_OUT_PORTS*CREDIT_BITS   current credits per port (debug/status)
// BEHAVIOUR
//  Reset: dout=0, req_ack=0, rr pointer=0, every credit=INIT_CREDITS, state=IDLE. Reset mid-packet drops it; no replay after reset.
//  Eligible(i) = req_vld[i] & req_pkt_i[PACKET_BITS-1] & credit[i]!=0.
//  Grant: in IDLE/SEND with resend=0, first eligible port searching from rr_ptr upward, wrapping at NUM_OUT_PORTS-1 -> 0.
//   Grant cycle: req_ack[g]=1 (combinational, same cycle as req_vld sampled); next edge dout<=req_pkt_g, credit[g]-=1, rr_ptr<=g+1 (wraps).
//   Latency: req_vld->req_ack 0 cycles; req_ack->packet on link 1 cycle. One packet/cycle max throughput.
//   No eligible port: next edge dout<=0, rr_ptr unchanged.
//  States:
//   IDLE  : dout invalid. grant -> SEND; else stay.
//   SEND  : dout valid. resend=1 -> HOLD (no grant, req_ack=0, dout unchanged); grant -> SEND; none -> IDLE.
//   HOLD  : dout held bit-exact, req_ack=0, no credit consumed. resend=0 -> grant evaluation as in IDLE (-> SEND or IDLE).
//  resend while IDLE is ignored (nothing to replay). Replayed packet never re-consumes a credit.
//  Credits: credit_upd_vld adds FREESPACE_UPDATE_SIZE to credit[credit_upd_port], saturating at INIT_CREDITS.
//   Same-cycle update and grant on one port: credit += FREESPACE_UPDATE_SIZE-1 (then saturate).
//   credit_upd_port >= NUM_OUT_PORTS: update ignored. Credit never underflows (credit 0 => not eligible).
//  Starvation-free: every continuously eligible port granted within NUM_OUT_PORTS grants.
//  All arithmetic unsigned, CREDIT_BITS wide; INIT_CREDITS+FREESPACE_UPDATE_SIZE must fit before saturation compare (use CREDIT_BITS+1 intermediate).
// STRUCTURE
//  Shared package leaf_pkg: packet field offsets (VALID_BIT, DEST_LEAF, DEST_PORT, PAYLOAD ranges), state enum {IDLE,SEND,HOLD}, default PACKET_BITS.
//  One sub-module: rr_arbiter (NUM_OUT_PORTS-wide masked round-robin, inputs eligible+rr_ptr, outputs one-hot grant + index + any).
//  Top holds FSM, output register, credit counter array.
// TESTING
//  Reset then single req on port 2, pkt=0x1_2345_6789_ABCD -> req_ack=4'b0100 same cycle, dout equals pkt next cycle, credit[2]=127.
//  All four ports req_vld held high 8 cycles -> grants 0,1,2,3,0,1,2,3; each credit = 126.
//  Port 1 issues 128 packets with no updates -> 129th req sees req_ack=0, dout=0; one credit_upd on port 1 -> credit 64, grants resume.
//  resend high 3 cycles after packet P sent -> dout==P for 4 cycles, req_ack=0, credit unchanged; next packet follows after release.
//  credit_upd on port 0 same cycle as port-0 grant at credit 100 -> credit 128 (saturated); upd with port=7 on 4-port build -> no change.
//  reset_bft asserted during HOLD -> next cycle dout=0, credits=128, state IDLE, no replay.

Source files
------------

// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf output path: packet field layout and scheduler states.
package leaf_pkg;

  localparam int unsigned DEF_PACKET_BITS = 49;

  localparam int unsigned VALID_BIT    = DEF_PACKET_BITS - 1;
  localparam int unsigned DEST_LEAF_HI = 47;
  localparam int unsigned DEST_LEAF_LO = 43;
  localparam int unsigned DEST_PORT_HI = 42;
  localparam int unsigned DEST_PORT_LO = 39;
  localparam int unsigned PAYLOAD_HI   = 38;
  localparam int unsigned PAYLOAD_LO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/leaf_out_arbiter_if.sv
// Request/credit/link bundle between the per-port packetisers, the arbiter and the BFT link.
interface leaf_out_arbiter_if #(
  parameter int unsigned PACKET_BITS   = 49,
  parameter int unsigned NUM_OUT_PORTS = 4,
  parameter int unsigned NUM_PORT_BITS = 4,
  parameter int unsigned CREDIT_BITS   = 8
);

  logic [NUM_OUT_PORTS-1:0]             req_vld;
  logic [NUM_OUT_PORTS*PACKET_BITS-1:0] req_pkt;
  logic [NUM_OUT_PORTS-1:0]             req_ack;
  logic                                 credit_upd_vld;
  logic [NUM_PORT_BITS-1:0]             credit_upd_port;
  logic                                 resend;
  logic [PACKET_BITS-1:0]               dout_leaf_interface2bft;
  logic [NUM_OUT_PORTS*CREDIT_BITS-1:0] credit_cnt;

  modport slave (
    input  req_vld, req_pkt, credit_upd_vld, credit_upd_port, resend,
    output req_ack, dout_leaf_interface2bft, credit_cnt
  );

  modport master (
    output req_vld, req_pkt, credit_upd_vld, credit_upd_port, resend,
    input  req_ack, dout_leaf_interface2bft, credit_cnt
  );

endinterface

// File: rtl/leaf_out_arbiter_rr_arbiter.sv
// Round-robin pick: first eligible port at or above rr_ptr, wrapping to port 0.
module rr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned PTR_BITS = 2
) (
  input  logic [N-1:0]        eligible,
  input  logic [PTR_BITS-1:0] rr_ptr,
  output logic [N-1:0]        grant,
  output logic [PTR_BITS-1:0] grant_idx,
  output logic                any
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && eligible[idx]) begin
        any            = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = PTR_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Credit-based round-robin scheduler for one leaf's BFT output link, with resend hold/replay.
module leaf_out_arbiter
  import leaf_pkg::*;
#(
  parameter int unsigned PACKET_BITS           = DEF_PACKET_BITS,
  parameter int unsigned NUM_OUT_PORTS         = 4,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned CREDIT_BITS           = 8,
  parameter int unsigned INIT_CREDITS          = 128,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64
) (
  input logic clk_bft,
  input logic reset_bft,
  leaf_out_arbiter_if.slave bus
);

  localparam int unsigned PTR_BITS = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [PTR_BITS-1:0]  LAST_PORT = PTR_BITS'(NUM_OUT_PORTS - 1);
  localparam logic [CREDIT_BITS:0] INIT_W    = (CREDIT_BITS+1)'(INIT_CREDITS);
  localparam logic [CREDIT_BITS:0] UPD_W     = (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);

  state_e                   state_q;
  logic [PACKET_BITS-1:0]   dout_q;
  logic [PTR_BITS-1:0]      rr_ptr_q;
  logic [CREDIT_BITS-1:0]   credit_q [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] grant;
  logic [NUM_OUT_PORTS-1:0] ack;
  logic [PTR_BITS-1:0]      grant_idx;
  logic                     any;
  logic                     grant_en;
  logic [PACKET_BITS-1:0]   pkt_sel;
  logic [PTR_BITS-1:0]      ptr_next;
  logic [CREDIT_BITS:0]     sum;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = bus.req_vld[i] & bus.req_pkt[i*PACKET_BITS + PACKET_BITS - 1] &
                    (credit_q[i] != '0);
    end
  end

  rr_arbiter #(
    .N        (NUM_OUT_PORTS),
    .PTR_BITS (PTR_BITS)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Resend only matters when something is on the link to replay.
  assign grant_en = !reset_bft && !((state_q != IDLE) && bus.resend);
  assign ack      = (grant_en && any) ? grant : '0;
  assign pkt_sel  = bus.req_pkt[grant_idx*PACKET_BITS +: PACKET_BITS];
  assign ptr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk_bft) begin
    if (reset_bft) begin
      state_q  <= IDLE;
      dout_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      unique case (state_q)
        SEND, HOLD: begin
          if (bus.resend) begin
            state_q <= HOLD;
          end else if (any) begin
            state_q  <= SEND;
            dout_q   <= pkt_sel;
            rr_ptr_q <= ptr_next;
          end else begin
            state_q <= IDLE;
            dout_q  <= '0;
          end
        end
        default: begin
          if (any) begin
            state_q  <= SEND;
            dout_q   <= pkt_sel;
            rr_ptr_q <= ptr_next;
          end else begin
            state_q <= IDLE;
            dout_q  <= '0;
          end
        end
      endcase
    end
  end

  // Ports >= NUM_OUT_PORTS never match an index, so such updates fall away.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      sum = {1'b0, credit_q[i]};
      if (bus.credit_upd_vld && (bus.credit_upd_port == NUM_PORT_BITS'(i))) sum = sum + UPD_W;
      if (ack[i]) sum = sum - 1'b1;
      credit_d[i] = (sum > INIT_W) ? INIT_W[CREDIT_BITS-1:0] : sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk_bft) begin
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      if (reset_bft) credit_q[i] <= INIT_W[CREDIT_BITS-1:0];
      else           credit_q[i] <= credit_d[i];
    end
  end

  always_comb begin
    bus.credit_cnt = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      bus.credit_cnt[i*CREDIT_BITS +: CREDIT_BITS] = credit_q[i];
    end
  end

  assign bus.req_ack                 = ack;
  assign bus.dout_leaf_interface2bft = dout_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Directed bench for leaf_out_arbiter: grants, round-robin order, credits, resend hold and reset.
module tb_leaf_out_arbiter;

  localparam int unsigned PB = 49;
  localparam int unsigned NP = 4;

  logic clk_bft = 1'b0;
  logic reset_bft;
  int   passed = 0;
  int   total  = 0;
  int   acks;

  logic [PB-1:0] pkts [NP];
  logic [PB-1:0] p_a;
  logic [PB-1:0] p_b;

  leaf_out_arbiter_if #(
    .PACKET_BITS   (PB),
    .NUM_OUT_PORTS (NP),
    .NUM_PORT_BITS (4),
    .CREDIT_BITS   (8)
  ) bus ();

  leaf_out_arbiter #(
    .PACKET_BITS           (PB),
    .NUM_OUT_PORTS         (NP),
    .NUM_PORT_BITS         (4),
    .CREDIT_BITS           (8),
    .INIT_CREDITS          (128),
    .FREESPACE_UPDATE_SIZE (64)
  ) dut (
    .clk_bft   (clk_bft),
    .reset_bft (reset_bft),
    .bus       (bus)
  );

  always #5 clk_bft = ~clk_bft;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_bft);
    #1;
  endtask

  function automatic logic [7:0] credit(input int i);
    return bus.credit_cnt[i*8 +: 8];
  endfunction

  task automatic set_pkt(input int i, input logic [PB-1:0] p);
    bus.req_pkt[i*PB +: PB] = p;
  endtask

  task automatic do_reset();
    bus.req_vld         = '0;
    bus.req_pkt         = '0;
    bus.credit_upd_vld  = 1'b0;
    bus.credit_upd_port = '0;
    bus.resend          = 1'b0;
    reset_bft           = 1'b1;
    tick();
    tick();
    reset_bft = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NP; i++) pkts[i] = {1'b1, 16'(16'hA000 + i), 32'(32'h1000_0000 * (i + 1))};

    // Reset state
    do_reset();
    check("reset_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);
    check("reset_ack", 64'(bus.req_ack), 64'h0);
    for (int i = 0; i < NP; i++) check("reset_credit", 64'(credit(i)), 64'd128);

    // Single request on port 2
    p_a = 49'h1_2345_6789_ABCD;
    set_pkt(2, p_a);
    bus.req_vld = 4'b0100;
    #1 check("p2_ack", 64'(bus.req_ack), 64'b0100);
    tick();
    bus.req_vld = '0;
    check("p2_dout", 64'(bus.dout_leaf_interface2bft), 64'(p_a));
    check("p2_credit", 64'(credit(2)), 64'd127);
    tick();
    check("p2_idle_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);

    // All four ports continuously requesting: strict rotation from port 0
    do_reset();
    for (int i = 0; i < NP; i++) set_pkt(i, pkts[i]);
    bus.req_vld = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1 check("rr_ack", 64'(bus.req_ack), 64'(1 << (c % 4)));
      tick();
      check("rr_dout", 64'(bus.dout_leaf_interface2bft), 64'(pkts[c % 4]));
    end
    bus.req_vld = '0;
    for (int i = 0; i < NP; i++) check("rr_credit", 64'(credit(i)), 64'd126);

    // Request with valid bit clear is not eligible
    set_pkt(0, {1'b0, 48'h1234});
    bus.req_vld = 4'b0001;
    #1 check("novalid_ack", 64'(bus.req_ack), 64'h0);
    bus.req_vld = '0;
    tick();

    // Exhaust port 1 credits
    do_reset();
    set_pkt(1, pkts[1]);
    bus.req_vld = 4'b0010;
    acks = 0;
    for (int c = 0; c < 128; c++) begin
      #1 if (bus.req_ack == 4'b0010) acks++;
      tick();
    end
    check("exh_acks", 64'(acks), 64'd128);
    check("exh_credit0", 64'(credit(1)), 64'd0);
    #1 check("exh_ack129", 64'(bus.req_ack), 64'h0);
    tick();
    check("exh_dout129", 64'(bus.dout_leaf_interface2bft), 64'h0);
    bus.credit_upd_vld  = 1'b1;
    bus.credit_upd_port = 4'd1;
    #1 check("exh_upd_ack", 64'(bus.req_ack), 64'h0);
    tick();
    bus.credit_upd_vld = 1'b0;
    check("exh_credit64", 64'(credit(1)), 64'd64);
    #1 check("exh_resume_ack", 64'(bus.req_ack), 64'b0010);
    tick();
    check("exh_resume_dout", 64'(bus.dout_leaf_interface2bft), 64'(pkts[1]));
    check("exh_credit63", 64'(credit(1)), 64'd63);
    bus.req_vld = '0;
    tick();

    // Resend holds P for 3 cycles, then the queued packet on port 1 follows
    do_reset();
    p_a = {1'b1, 48'hDEAD_BEEF_0001};
    p_b = {1'b1, 48'hCAFE_F00D_0002};
    set_pkt(0, p_a);
    set_pkt(1, p_b);
    bus.req_vld = 4'b0001;
    #1 check("rs_ack_p", 64'(bus.req_ack), 64'b0001);
    tick();
    check("rs_dout_sent", 64'(bus.dout_leaf_interface2bft), 64'(p_a));
    bus.req_vld = 4'b0010;
    bus.resend  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 check("rs_hold_ack", 64'(bus.req_ack), 64'h0);
      tick();
      check("rs_hold_dout", 64'(bus.dout_leaf_interface2bft), 64'(p_a));
    end
    check("rs_credit0", 64'(credit(0)), 64'd127);
    check("rs_credit1", 64'(credit(1)), 64'd128);
    bus.resend = 1'b0;
    #1 check("rs_release_ack", 64'(bus.req_ack), 64'b0010);
    tick();
    bus.req_vld = '0;
    check("rs_next_dout", 64'(bus.dout_leaf_interface2bft), 64'(p_b));
    check("rs_credit0_after", 64'(credit(0)), 64'd127);
    check("rs_credit1_after", 64'(credit(1)), 64'd127);
    tick();

    // Update coinciding with a grant saturates; out-of-range port is ignored
    do_reset();
    set_pkt(0, pkts[0]);
    set_pkt(3, pkts[3]);
    bus.req_vld = 4'b0001;
    for (int c = 0; c < 28; c++) tick();
    check("sat_credit100", 64'(credit(0)), 64'd100);
    bus.credit_upd_vld  = 1'b1;
    bus.credit_upd_port = 4'd0;
    #1 check("sat_ack", 64'(bus.req_ack), 64'b0001);
    tick();
    bus.credit_upd_vld = 1'b0;
    bus.req_vld        = 4'b1000;
    check("sat_credit128", 64'(credit(0)), 64'd128);
    #1 check("p3_ack", 64'(bus.req_ack), 64'b1000);
    tick();
    bus.req_vld         = '0;
    bus.credit_upd_vld  = 1'b1;
    bus.credit_upd_port = 4'd7;
    check("p3_credit", 64'(credit(3)), 64'd127);
    tick();
    bus.credit_upd_vld = 1'b0;
    check("oor_credit0", 64'(credit(0)), 64'd128);
    check("oor_credit1", 64'(credit(1)), 64'd128);
    check("oor_credit2", 64'(credit(2)), 64'd128);
    check("oor_credit3", 64'(credit(3)), 64'd127);

    // Reset while holding drops the packet
    do_reset();
    p_a = {1'b1, 48'h0BAD_0BAD_0BAD};
    p_b = {1'b1, 48'h0600_D600_D600};
    set_pkt(2, p_a);
    bus.req_vld = 4'b0100;
    tick();
    bus.req_vld = '0;
    bus.resend  = 1'b1;
    tick();
    check("rst_hold_dout", 64'(bus.dout_leaf_interface2bft), 64'(p_a));
    reset_bft = 1'b1;
    tick();
    reset_bft = 1'b0;
    check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);
    for (int i = 0; i < NP; i++) check("rst_credit", 64'(credit(i)), 64'd128);
    set_pkt(2, p_b);
    bus.req_vld = 4'b0100;
    #1 check("rst_idle_ack", 64'(bus.req_ack), 64'b0100);
    tick();
    bus.req_vld = '0;
    bus.resend  = 1'b0;
    check("rst_new_dout", 64'(bus.dout_leaf_interface2bft), 64'(p_b));
    tick();
    check("rst_final_dout", 64'(bus.dout_leaf_interface2bft), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
